// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES-128 decryption core:
// FSM state type, round constants, inverse S-box and GF(2^8) helpers.
package aes_dec_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_ADDK   = 3'd2,
        S_ROUND  = 3'd3,
        S_FINAL  = 3'd4,
        S_DONE   = 3'd5
    } dec_state_e;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // RotWord: [a0 a1 a2 a3] -> [a1 a2 a3 a0], a0 in the top byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse AES round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last_i).
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] res_o
);

    logic [7:0] ark_s [16];
    logic [7:0] mc_s  [16];

    // Byte n sits at row n%4, column n/4; InvShiftRows rotates row r right by r.
    for (genvar n = 0; n < 16; n++) begin : g_byte
        localparam int ROW = n % 4;
        localparam int COL = n / 4;
        localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
        assign ark_s[n] = inv_sbox(st_i[127-8*SRC -: 8]) ^ rk_i[127-8*n -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mc_s[4*c+0] = gf_mul14(ark_s[4*c]) ^ gf_mul11(ark_s[4*c+1]) ^ gf_mul13(ark_s[4*c+2]) ^ gf_mul9(ark_s[4*c+3]);
        assign mc_s[4*c+1] = gf_mul9(ark_s[4*c])  ^ gf_mul14(ark_s[4*c+1]) ^ gf_mul11(ark_s[4*c+2]) ^ gf_mul13(ark_s[4*c+3]);
        assign mc_s[4*c+2] = gf_mul13(ark_s[4*c]) ^ gf_mul9(ark_s[4*c+1])  ^ gf_mul14(ark_s[4*c+2]) ^ gf_mul11(ark_s[4*c+3]);
        assign mc_s[4*c+3] = gf_mul11(ark_s[4*c]) ^ gf_mul13(ark_s[4*c+1]) ^ gf_mul9(ark_s[4*c+2])  ^ gf_mul14(ark_s[4*c+3]);
    end

    for (genvar n = 0; n < 16; n++) begin : g_out
        assign res_o[127-8*n -: 8] = last_i ? ark_s[n] : mc_s[n];
    end

endmodule

// File: rtl/sbox.sv
// Forward AES S-box lookup (combinational), shared with the cipher block.
module sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [7:0] SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_o = SBOX_TABLE[in_i];

endmodule

// File: rtl/aes_decipher_iter.sv
// Iterative AES-128 decryption core, one inverse round per clock.
// Key is expanded forward to K10, then round keys are regenerated backwards.
// Optional feature: define AES_DEC_KEYCACHE_EN to keep the last K10 and its key,
// letting a repeated key skip the forward expansion.
module aes_decipher_iter
    import aes_dec_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] datain,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dataout
);

    localparam logic [3:0] LAST_CNT = 4'(NR - 1);

    dec_state_e   state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] dataout_q, dataout_d;

    logic [31:0]  w0_s, w1_s, w2_s, w3_s;
    logic [31:0]  inv_w3_s;
    logic [31:0]  sw_in_s, sw_rot_s, sw_sub_s;
    logic [7:0]   rcon_s;
    logic [127:0] key_fwd_s, key_inv_s;
    logic [127:0] round_s;
    logic         accept_s;
    logic         hit_s;
    logic [127:0] cache_k10_s;

    assign w0_s     = rk_q[127:96];
    assign w1_s     = rk_q[95:64];
    assign w2_s     = rk_q[63:32];
    assign w3_s     = rk_q[31:0];
    assign inv_w3_s = w3_s ^ w2_s;
    assign accept_s = (state_q == S_IDLE) && in_valid && in_ready_q;

    // SubWord input: current w3 when expanding forward, recovered older w3 when stepping back
    always_comb begin
        if (state_q == S_KEYEXP) begin
            sw_in_s = w3_s;
        end else begin
            sw_in_s = inv_w3_s;
        end
    end

    assign sw_rot_s = rot_word(sw_in_s);

    for (genvar g = 0; g < 4; g++) begin : g_subword
        sbox u_sbox (
            .in_i  (sw_rot_s[8*g +: 8]),
            .out_o (sw_sub_s[8*g +: 8])
        );
    end

    // Round constant for the key step taken in the current state
    always_comb begin
        case (state_q)
            S_KEYEXP: rcon_s = RCON[cnt_q];
            S_ADDK:   rcon_s = RCON[LAST_CNT];
            S_ROUND:  rcon_s = RCON[cnt_q - 4'd1];
            default:  rcon_s = 8'h00;
        endcase
    end

    // Forward and inverse key steps share the four S-boxes above
    always_comb begin
        logic [31:0] f0, f1, f2;
        f0        = w0_s ^ sw_sub_s ^ {rcon_s, 24'h000000};
        f1        = w1_s ^ f0;
        f2        = w2_s ^ f1;
        key_fwd_s = {f0, f1, f2, w3_s ^ f2};
        key_inv_s = {w0_s ^ sw_sub_s ^ {rcon_s, 24'h000000}, w1_s ^ w0_s, w2_s ^ w1_s, inv_w3_s};
    end

    aes_inv_round u_round (
        .st_i   (st_q),
        .rk_i   (rk_q),
        .last_i (state_q == S_FINAL),
        .res_o  (round_s)
    );

`ifdef AES_DEC_KEYCACHE_EN
    logic [127:0] cache_key_q;
    logic [127:0] cache_k10_q;
    logic         cache_vld_q;

    assign hit_s       = cache_vld_q && (cache_key_q == key);
    assign cache_k10_s = cache_k10_q;

    // Key cache: invalidate and remember the key on a miss, fill K10 when expansion completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_key_q <= 128'h0;
            cache_k10_q <= 128'h0;
            cache_vld_q <= 1'b0;
        end else begin
            if (accept_s && !hit_s) begin
                cache_key_q <= key;
                cache_vld_q <= 1'b0;
            end
            if ((state_q == S_KEYEXP) && (cnt_q == LAST_CNT)) begin
                cache_k10_q <= key_fwd_s;
                cache_vld_q <= 1'b1;
            end
        end
    end
`else
    assign hit_s       = 1'b0;
    assign cache_k10_s = 128'h0;
`endif

    // Next-state and datapath control for the decryption sequence
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        dataout_d   = dataout_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    st_d       = datain;
                    cnt_d      = 4'd0;
                    in_ready_d = 1'b0;
                    if (hit_s) begin
                        rk_d    = cache_k10_s;
                        state_d = S_ADDK;
                    end else begin
                        rk_d    = key;
                        state_d = S_KEYEXP;
                    end
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_KEYEXP: begin
                rk_d  = key_fwd_s;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_ADDK;
                end else begin
                    state_d = S_KEYEXP;
                end
            end
            S_ADDK: begin
                st_d    = st_q ^ rk_q;
                rk_d    = key_inv_s;
                cnt_d   = LAST_CNT;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                st_d  = round_s;
                rk_d  = key_inv_s;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_FINAL;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_FINAL: begin
                dataout_d   = round_s;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset discards any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            st_q        <= 128'h0;
            rk_q        <= 128'h0;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dataout_q   <= 128'h0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dataout_q   <= dataout_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dataout   = dataout_q;

endmodule

// File: tb/tb_aes_decipher_iter.sv
// Self-checking bench for aes_decipher_iter. The reference model builds the
// S-box from GF(2^8) inversion plus the affine map and encrypts random blocks.
module tb_aes_decipher_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] datain = 128'h0;
    logic [127:0] key = 128'h0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] dataout;

`ifdef AES_DEC_KEYCACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int LAT_BOUND = 60;

    int total = 0;
    int bad = 0;
    logic [7:0] sb [256];
    bit cache_vld_m = 1'b0;
    logic [127:0] cache_key_m = 128'h0;

    always #5 clk = ~clk;

    aes_decipher_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic int exp_lat(input logic [127:0] k);
        return (CACHE_EN && cache_vld_m && cache_key_m == k) ? 11 : 21;
    endfunction

    // Present one block at a negedge, measure edges until out_valid, return dataout.
    task automatic run_block(input logic [127:0] k, input logic [127:0] ct, input logic rdy,
                             output logic [127:0] pt, output int lat);
        in_valid = 1'b1;
        key = k;
        datain = ct;
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        datain = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (out_valid !== 1'b1 && lat < LAT_BOUND) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        pt = dataout;
        cache_vld_m = 1'b1;
        cache_key_m = k;
    endtask

    task automatic recover();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cache_vld_m = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (dataout !== 128'h0) begin bad++; $display("FAIL reset_dataout got=%h want=0", dataout); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_vector(input string name, input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pexp);
        logic [127:0] pt;
        int lat;
        int el;
        el = exp_lat(k);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_pre_ready got=%b want=1", name, in_ready); end
        run_block(k, ct, 1'b1, pt, lat);
        total++; if (pt !== pexp) begin bad++; $display("FAIL %s_data got=%h want=%h", name, pt, pexp); end
        total++; if (lat !== el) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, el); end
        if (lat >= LAT_BOUND) recover();
        else begin
            @(posedge clk);
            @(negedge clk);
            total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL %s_transfer got=%b want=01", name, {out_valid, in_ready}); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt;
        int lat;
        int el;
        el = exp_lat(K1);
        run_block(K1, C1, 1'b0, pt, lat);
        total++; if (pt !== P1) begin bad++; $display("FAIL bp_data got=%h want=%h", pt, P1); end
        total++; if (lat !== el) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, el); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            key = {$urandom, $urandom, $urandom, $urandom};
            datain = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL bp_hold_flags got=%b want=10", {out_valid, in_ready}); end
            total++; if (dataout !== P1) begin bad++; $display("FAIL bp_hold_data got=%h want=%h", dataout, P1); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b want=01", {out_valid, in_ready}); end
        repeat (3) @(negedge clk);
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_no_accept got=%b want=01", {out_valid, in_ready}); end
    endtask

    task automatic test_reset_midflight();
        in_valid = 1'b1;
        key = K1;
        datain = C1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        total++; if (dataout !== 128'h0) begin bad++; $display("FAIL midrst_dataout got=%h want=0", dataout); end
        cache_vld_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL midrst_no_output got=%b want=01", {out_valid, in_ready}); end
        test_vector("midrst_c1", K1, C1, P1);
    endtask

    task automatic test_key_reuse();
        test_vector("reuse_c1_first", K1, C1, P1);
        test_vector("reuse_c1_second", K1, C1, P1);
        test_vector("reuse_b", KB, CB, PB);
    endtask

    task automatic test_random();
        logic [127:0] k;
        logic [127:0] prev_k = K1;
        logic [127:0] pt_ref;
        logic [127:0] ct;
        logic [127:0] pt;
        logic rdy;
        int lat;
        int el;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) k = prev_k;
            else k = {$urandom, $urandom, $urandom, $urandom};
            prev_k = k;
            pt_ref = {$urandom, $urandom, $urandom, $urandom};
            ct = ref_encrypt(pt_ref, k);
            rdy = ($urandom_range(0, 3) != 0);
            el = exp_lat(k);
            run_block(k, ct, rdy, pt, lat);
            total++; if (pt !== pt_ref) begin bad++; $display("FAIL rand_data i=%0d got=%h want=%h", i, pt, pt_ref); end
            total++; if (lat !== el) begin bad++; $display("FAIL rand_latency i=%0d got=%0d want=%0d", i, lat, el); end
            if (lat >= LAT_BOUND) recover();
            else begin
                if (!rdy) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        @(negedge clk);
                    end
                    total++; if ({out_valid, dataout} !== {1'b1, pt_ref}) begin bad++; $display("FAIL rand_hold i=%0d got=%b/%h want=1/%h", i, out_valid, dataout, pt_ref); end
                    out_ready = 1'b1;
                end
                @(posedge clk);
                @(negedge clk);
                total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL rand_transfer i=%0d got=%b want=01", i, {out_valid, in_ready}); end
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        if (ref_encrypt(P1, K1) !== C1) begin
            $display("FAIL ref_model got=%h want=%h", ref_encrypt(P1, K1), C1);
            $fatal(1, "reference model broken");
        end
        test_reset();
        test_vector("fips_c1", K1, C1, P1);
        test_vector("fips_b", KB, CB, PB);
        test_backpressure();
        test_reset_midflight();
        test_key_reuse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
